// File: rtl/sm83_regfile_mp_if.sv
// Bus bundle for sm83_regfile_mp: read selects/data, write strobes, PC control and status.
// Write strobes carry no handshake: each strobe is a single-cycle request sampled on the rising edge and always accepted.
interface sm83_regfile_mp_if #(
  parameter int NUM_RD_PORTS = 2,
  parameter int DATA_W       = 8
);
  logic [NUM_RD_PORTS*4-1:0]        rd8_sel;
  logic [NUM_RD_PORTS*DATA_W-1:0]   rd8_data;
  logic [NUM_RD_PORTS*2-1:0]        rd16_sel;
  logic [NUM_RD_PORTS*2*DATA_W-1:0] rd16_data;
  logic                             wr8_en;
  logic [3:0]                       wr8_sel;
  logic [DATA_W-1:0]                wr8_data;
  logic                             wr16_en;
  logic [1:0]                       wr16_sel;
  logic [2*DATA_W-1:0]              wr16_data;
  logic [3:0]                       f_wr_mask;
  logic [3:0]                       f_wr_data;
  logic                             idu_en;
  logic [1:0]                       idu_sel;
  logic                             idu_dec;
  logic                             pc_inc;
  logic                             pc_load;
  logic [2*DATA_W-1:0]              pc_load_data;
  logic [2*DATA_W-1:0]              pc;
  logic [2*DATA_W-1:0]              sp;
  logic [3:0]                       flags;
  logic                             wr_conflict;

  modport master (
    output rd8_sel, rd16_sel, wr8_en, wr8_sel, wr8_data, wr16_en, wr16_sel, wr16_data,
           f_wr_mask, f_wr_data, idu_en, idu_sel, idu_dec, pc_inc, pc_load, pc_load_data,
    input  rd8_data, rd16_data, pc, sp, flags, wr_conflict
  );

  modport slave (
    input  rd8_sel, rd16_sel, wr8_en, wr8_sel, wr8_data, wr16_en, wr16_sel, wr16_data,
           f_wr_mask, f_wr_data, idu_en, idu_sel, idu_dec, pc_inc, pc_load, pc_load_data,
    output rd8_data, rd16_data, pc, sp, flags, wr_conflict
  );
endinterface

// File: rtl/sm83_regfile_mp.sv
// SM83 multi-port register file with IDU, PC sequencer, masked flag writes and collision flag.
// Optional macro SM83_RF_BYPASS_EN forwards same-cycle write results to all read ports.
module sm83_regfile_mp #(
  parameter int                    NUM_RD_PORTS = 2,
  parameter int                    DATA_W       = 8,
  parameter logic [2*DATA_W-1:0]   PC_RESET     = '0,
  parameter logic [2*DATA_W-1:0]   SP_RESET     = '0
) (
  input logic              clk,
  input logic              rst_n,
  sm83_regfile_mp_if.slave bus
);
  localparam int            PW     = 2*DATA_W;
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [3:0]    SEL_A  = 4'd6;
  localparam logic [3:0]    SEL_F  = 4'd7;
  localparam logic [3:0]    SEL_IR = 4'd8;
  localparam logic [3:0]    SEL_IE = 4'd9;

  // Pair storage indexed by the 16-bit select code: BC, DE, HL, SP.
  logic [PW-1:0]     pair_q [4];
  logic [PW-1:0]     pair_n [4];
  logic [DATA_W-1:0] a_q, a_n, ir_q, ir_n, ie_q, ie_n;
  logic [3:0]        f_q, f_n;
  logic [PW-1:0]     pc_q, pc_n;
  logic              conflict_q, conflict_n;
  logic [PW-1:0]     idu_res;
  logic              wr8_pair_hit;

  assign idu_res      = bus.idu_dec ? pair_q[bus.idu_sel] - ONE : pair_q[bus.idu_sel] + ONE;
  assign wr8_pair_hit = (bus.wr8_sel < 4'd6);

  // Lowest priority first so later assignments win on any shared byte.
  always_comb begin
    for (int i = 0; i < 4; i++) pair_n[i] = pair_q[i];
    a_n  = a_q;
    f_n  = f_q;
    ir_n = ir_q;
    ie_n = ie_q;
    if (bus.idu_en)  pair_n[bus.idu_sel]  = idu_res;
    if (bus.wr16_en) pair_n[bus.wr16_sel] = bus.wr16_data;
    if (bus.wr8_en) begin
      if (wr8_pair_hit) begin
        if (bus.wr8_sel[0]) pair_n[bus.wr8_sel[2:1]][DATA_W-1:0]  = bus.wr8_data;
        else                pair_n[bus.wr8_sel[2:1]][PW-1:DATA_W] = bus.wr8_data;
      end else begin
        case (bus.wr8_sel)
          SEL_A:   a_n  = bus.wr8_data;
          SEL_F:   f_n  = bus.wr8_data[DATA_W-1 -: 4];
          SEL_IR:  ir_n = bus.wr8_data;
          SEL_IE:  ie_n = bus.wr8_data;
          default: ;
        endcase
      end
    end
    f_n = (f_n & ~bus.f_wr_mask) | (bus.f_wr_data & bus.f_wr_mask);
  end

  // A byte is contested when two of {wr8, wr16, idu} land on it; only pairs can be shared.
  always_comb begin
    conflict_n = 1'b0;
    if (bus.wr16_en && bus.idu_en && (bus.wr16_sel == bus.idu_sel)) conflict_n = 1'b1;
    if (bus.wr8_en && wr8_pair_hit) begin
      if (bus.wr16_en && (bus.wr16_sel == bus.wr8_sel[2:1])) conflict_n = 1'b1;
      if (bus.idu_en  && (bus.idu_sel  == bus.wr8_sel[2:1])) conflict_n = 1'b1;
    end
  end

  always_comb begin
    pc_n = pc_q;
    if (bus.pc_load)     pc_n = bus.pc_load_data;
    else if (bus.pc_inc) pc_n = pc_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q[0]  <= '0;
      pair_q[1]  <= '0;
      pair_q[2]  <= '0;
      pair_q[3]  <= SP_RESET;
      a_q        <= '0;
      f_q        <= '0;
      ir_q       <= '0;
      ie_q       <= '0;
      pc_q       <= PC_RESET;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) pair_q[i] <= pair_n[i];
      a_q        <= a_n;
      f_q        <= f_n;
      ir_q       <= ir_n;
      ie_q       <= ie_n;
      pc_q       <= pc_n;
      conflict_q <= conflict_n;
    end
  end

  // Read view: post-edge values when forwarding, stored values otherwise.
  logic [PW-1:0]     v_pair [4];
  logic [DATA_W-1:0] v_a, v_ir, v_ie;
  logic [3:0]        v_f;

  always_comb begin
`ifdef SM83_RF_BYPASS_EN
    for (int i = 0; i < 4; i++) v_pair[i] = pair_n[i];
    v_a  = a_n;
    v_f  = f_n;
    v_ir = ir_n;
    v_ie = ie_n;
`else
    for (int i = 0; i < 4; i++) v_pair[i] = pair_q[i];
    v_a  = a_q;
    v_f  = f_q;
    v_ir = ir_q;
    v_ie = ie_q;
`endif
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [3:0]        s8;
    logic [DATA_W-1:0] v8;
    assign s8 = bus.rd8_sel[p*4 +: 4];
    always_comb begin
      v8 = '0;
      if (s8 < 4'd6) begin
        v8 = s8[0] ? v_pair[s8[2:1]][DATA_W-1:0] : v_pair[s8[2:1]][PW-1:DATA_W];
      end else begin
        case (s8)
          SEL_A:   v8 = v_a;
          SEL_F:   v8 = {v_f, {(DATA_W-4){1'b0}}};
          SEL_IR:  v8 = v_ir;
          SEL_IE:  v8 = v_ie;
          default: v8 = '0;
        endcase
      end
    end
    assign bus.rd8_data[p*DATA_W +: DATA_W] = v8;
    assign bus.rd16_data[p*PW +: PW]        = v_pair[bus.rd16_sel[p*2 +: 2]];
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = pair_q[3];
  assign bus.flags       = f_q;
  assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_sm83_regfile_mp.sv
// Self-checking bench for sm83_regfile_mp: directed scenarios plus random traffic against a byte-array model.
module tb_sm83_regfile_mp;
  localparam int NP = 2;
  localparam int W  = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm83_regfile_mp_if #(.NUM_RD_PORTS(NP), .DATA_W(W)) bus ();

  sm83_regfile_mp #(
    .NUM_RD_PORTS(NP), .DATA_W(W), .PC_RESET(16'h0100), .SP_RESET(16'hFFFE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes indexed by 8-bit select code: 0 B,1 C,2 D,3 E,4 H,5 L,6 A,7 F,8 IR,9 IE; 10 SPH, 11 SPL.
  logic [7:0]  m  [12];
  logic [7:0]  nx [12];
  logic [15:0] m_pc, nx_pc;
  logic        nx_conf;

  function automatic int hidx(input int p);
    return (p == 3) ? 10 : 2*p;
  endfunction

  function automatic logic [7:0] view8(input int code);
    if (code >= 10) return 8'h00;
`ifdef SM83_RF_BYPASS_EN
    return nx[code];
`else
    return m[code];
`endif
  endfunction

  function automatic logic [15:0] view16(input int p);
    int h;
    h = hidx(p);
`ifdef SM83_RF_BYPASS_EN
    return {nx[h], nx[h+1]};
`else
    return {m[h], m[h+1]};
`endif
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = 8'h00;
    m[10] = 8'hFF;
    m[11] = 8'hFE;
    m_pc  = 16'h0100;
    exp_q.delete();
  endtask

  task automatic model_next();
    int hits[12];
    int h;
    logic [15:0] v;
    nx = m;
    foreach (hits[i]) hits[i] = 0;
    if (bus.idu_en) begin
      h = hidx(int'(bus.idu_sel));
      v = {m[h], m[h+1]};
      v = bus.idu_dec ? v - 16'd1 : v + 16'd1;
      nx[h] = v[15:8]; nx[h+1] = v[7:0];
      hits[h]++; hits[h+1]++;
    end
    if (bus.wr16_en) begin
      h = hidx(int'(bus.wr16_sel));
      nx[h] = bus.wr16_data[15:8]; nx[h+1] = bus.wr16_data[7:0];
      hits[h]++; hits[h+1]++;
    end
    if (bus.wr8_en && bus.wr8_sel < 4'd10) begin
      h = int'(bus.wr8_sel);
      nx[h] = (h == 7) ? {bus.wr8_data[7:4], 4'h0} : bus.wr8_data;
      hits[h]++;
    end
    for (int k = 0; k < 4; k++) if (bus.f_wr_mask[k]) nx[7][4+k] = bus.f_wr_data[k];
    nx_conf = 1'b0;
    foreach (hits[i]) if (hits[i] > 1) nx_conf = 1'b1;
    nx_pc = bus.pc_load ? bus.pc_load_data : (bus.pc_inc ? m_pc + 16'd1 : m_pc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wr8_en = 1'b0; bus.wr8_sel = 4'd0; bus.wr8_data = 8'h00;
    bus.wr16_en = 1'b0; bus.wr16_sel = 2'd0; bus.wr16_data = 16'h0000;
    bus.f_wr_mask = 4'h0; bus.f_wr_data = 4'h0;
    bus.idu_en = 1'b0; bus.idu_sel = 2'd0; bus.idu_dec = 1'b0;
    bus.pc_inc = 1'b0; bus.pc_load = 1'b0; bus.pc_load_data = 16'h0000;
  endtask

  task automatic rand_inputs();
    bus.wr8_en       = ($urandom_range(0, 2) == 0);
    bus.wr8_sel      = 4'($urandom_range(0, 15));
    bus.wr8_data     = 8'($urandom);
    bus.wr16_en      = ($urandom_range(0, 2) == 0);
    bus.wr16_sel     = 2'($urandom_range(0, 3));
    bus.wr16_data    = 16'($urandom);
    bus.f_wr_mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    bus.f_wr_data    = 4'($urandom);
    bus.idu_en       = ($urandom_range(0, 2) == 0);
    bus.idu_sel      = 2'($urandom_range(0, 3));
    bus.idu_dec      = 1'($urandom);
    bus.pc_inc       = 1'($urandom);
    bus.pc_load      = ($urandom_range(0, 7) == 0);
    bus.pc_load_data = 16'($urandom);
    for (int p = 0; p < NP; p++) begin
      bus.rd8_sel[p*4 +: 4]  = 4'($urandom_range(0, 15));
      bus.rd16_sel[p*2 +: 2] = 2'($urandom_range(0, 3));
    end
  endtask

  // One clock with the currently driven inputs; checks reads before the edge and state after it.
  task automatic cycle();
    #1;
    model_next();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rd8[%0d]", p), 32'(bus.rd8_data[p*8 +: 8]), 32'(view8(int'(bus.rd8_sel[p*4 +: 4]))));
      check($sformatf("rd16[%0d]", p), 32'(bus.rd16_data[p*16 +: 16]), 32'(view16(int'(bus.rd16_sel[p*2 +: 2]))));
    end
    @(posedge clk);
    m = nx;
    m_pc = nx_pc;
    exp_q.push_back(W'(nx_conf));
    #1;
    check("pc", 32'(bus.pc), 32'(m_pc));
    check("sp", 32'(bus.sp), 32'({m[10], m[11]}));
    check("flags", 32'(bus.flags), 32'(m[7][7:4]));
    check("wr_conflict", 32'(bus.wr_conflict), 32'(exp_q.pop_front()));
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, 32'(bus.pc), 32'h0100);
    check({tag, "_sp"}, 32'(bus.sp), 32'hFFFE);
    check({tag, "_rd8"}, 32'(bus.rd8_data), 32'h0000);
    check({tag, "_flags"}, 32'(bus.flags), 32'h0);
    check({tag, "_conflict"}, 32'(bus.wr_conflict), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    bus.rd8_sel = '0;
    bus.rd16_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.rd8_sel  = {4'd4, 4'd6};
    bus.rd16_sel = {2'd3, 2'd0};
    #1;
    check_reset_values("init");
    check("init_rd16_sp", 32'(bus.rd16_data[31:16]), 32'hFFFE);

    // HL write then L overwrite
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd2; bus.wr16_data = 16'hC0DE;
    cycle(); idle();
    bus.rd16_sel = {2'd2, 2'd2}; bus.rd8_sel = {4'd4, 4'd4};
    #1;
    check("hl_wr16", 32'(bus.rd16_data[15:0]), 32'hC0DE);
    check("h_both_ports", 32'(bus.rd8_data), 32'hC0C0);
    bus.wr8_en = 1'b1; bus.wr8_sel = 4'd5; bus.wr8_data = 8'h55;
    cycle(); idle();
    #1;
    check("hl_after_l", 32'(bus.rd16_data[31:16]), 32'hC055);

    // IDU wrap on HL and SP
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd2; bus.wr16_data = 16'hFFFF;
    cycle(); idle();
    bus.idu_en = 1'b1; bus.idu_sel = 2'd2;
    cycle(); idle();
    #1;
    check("idu_inc_wrap", 32'(bus.rd16_data[15:0]), 32'h0000);
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd3; bus.wr16_data = 16'h0000;
    cycle(); idle();
    bus.idu_en = 1'b1; bus.idu_sel = 2'd3; bus.idu_dec = 1'b1;
    cycle(); idle();
    #1;
    check("idu_dec_wrap_sp", 32'(bus.sp), 32'hFFFF);
    check("idu_no_flags", 32'(bus.flags), 32'h0);

    // Collision: wr8 H vs wr16 HL, IDU on DE independent
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd1; bus.wr16_data = 16'h0010;
    cycle(); idle();
    bus.wr8_en = 1'b1; bus.wr8_sel = 4'd4; bus.wr8_data = 8'h12;
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd2; bus.wr16_data = 16'hABCD;
    bus.idu_en = 1'b1; bus.idu_sel = 2'd1;
    cycle(); idle();
    bus.rd16_sel = {2'd1, 2'd2};
    #1;
    check("coll_hl", 32'(bus.rd16_data[15:0]), 32'h12CD);
    check("coll_de", 32'(bus.rd16_data[31:16]), 32'h0011);
    check("coll_flag_set", 32'(bus.wr_conflict), 32'h1);
    cycle();
    check("coll_flag_clear", 32'(bus.wr_conflict), 32'h0);

    // Flags: full write via wr8 then masked clear of n and c
    bus.wr8_en = 1'b1; bus.wr8_sel = 4'd7; bus.wr8_data = 8'hFF;
    cycle(); idle();
    bus.f_wr_mask = 4'b0101; bus.f_wr_data = 4'b0000;
    cycle(); idle();
    bus.rd8_sel = {4'd7, 4'd7};
    #1;
    check("flags_masked", 32'(bus.flags), 32'hA);
    check("rd8_f", 32'(bus.rd8_data[7:0]), 32'hA0);

    // PC sequencing
    bus.pc_load = 1'b1; bus.pc_load_data = 16'hFFFF;
    cycle(); idle();
    bus.pc_inc = 1'b1;
    cycle(); idle();
    check("pc_wrap", 32'(bus.pc), 32'h0000);
    bus.pc_inc = 1'b1; bus.pc_load = 1'b1; bus.pc_load_data = 16'h1234;
    cycle(); idle();
    check("pc_load_prio", 32'(bus.pc), 32'h1234);

    // Same-cycle visibility of an A write
    bus.wr8_en = 1'b1; bus.wr8_sel = 4'd6; bus.wr8_data = 8'h11;
    cycle();
    bus.wr8_data = 8'h77;
    bus.rd8_sel = {4'd6, 4'd6};
    #1;
`ifdef SM83_RF_BYPASS_EN
    check("a_same_cycle", 32'(bus.rd8_data[7:0]), 32'h77);
`else
    check("a_same_cycle", 32'(bus.rd8_data[7:0]), 32'h11);
`endif
    cycle(); idle();

    // Random traffic
    repeat (400) begin
      rand_inputs();
      cycle();
    end
    idle();

    // Reset mid-cycle with a live conflict and strobes still asserted
    bus.wr8_en = 1'b1; bus.wr8_sel = 4'd4; bus.wr8_data = 8'h9A;
    bus.wr16_en = 1'b1; bus.wr16_sel = 2'd2; bus.wr16_data = 16'h5A5A;
    bus.pc_inc = 1'b1; bus.idu_en = 1'b1; bus.idu_sel = 2'd3;
    bus.rd8_sel = {4'd4, 4'd5};
    cycle();
    check("pre_reset_conflict", 32'(bus.wr_conflict), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    repeat (20) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
